// File: rtl/bus_slave_region.sv
// bus_slave_region: 8088 bus-cycle slave for one memory or I/O region with ALE latch, decode, READY wait states and tri-state data
module bus_slave_region #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned BASE        = 'h00000,
    parameter int unsigned DEPTH       = 'h80000,
    parameter bit          IS_IO       = 1'b0,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_ale,
    input  logic              i_iom,
    input  logic              i_rd_n,
    input  logic              i_wr_n,
    input  logic [ADDR_W-1:0] i_addr,
    inout  wire  [DATA_W-1:0] io_data,
    output logic              o_ready,
    output logic              o_hit
);
    localparam int unsigned       OFF_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   LO    = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0]   HI    = (ADDR_W+1)'(BASE + DEPTH);
    localparam logic [3:0]        WS_M1 = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_READ, S_WRITE, S_TRI} state_t;

    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_hit;
    logic               r_dir;
    logic [3:0]         r_cnt;
    logic               r_wfirst;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [OFF_W-1:0]   w_off;
    logic               w_dec;
    logic               w_latch;
    logic               w_start;

    assign w_dec   = (i_iom == IS_IO) && ({1'b0, i_addr} >= LO) && ({1'b0, i_addr} < HI);
    assign w_off   = OFF_W'(r_addr - LO[ADDR_W-1:0]);
    assign w_latch = i_ale && (r_state == S_IDLE || r_state == S_ADDR);
    assign w_start = (r_state == S_ADDR) && !i_ale && r_hit && !(i_rd_n && i_wr_n);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_ale ? S_ADDR : S_IDLE;
            S_ADDR:  w_next = i_ale ? S_ADDR :
                              !r_hit ? S_IDLE :
                              !w_start ? S_ADDR :
                              (WAIT_STATES > 0) ? S_WAIT :
                              !i_rd_n ? S_READ : S_WRITE;
            S_WAIT:  w_next = (r_cnt != 4'd0) ? S_WAIT : r_dir ? S_READ : S_WRITE;
            S_READ:  w_next = i_rd_n ? S_TRI : S_READ;
            S_WRITE: w_next = i_wr_n ? S_TRI : S_WRITE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_hit    <= 1'b0;
            r_dir    <= 1'b0;
            r_cnt    <= 4'd0;
            r_wfirst <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_wfirst <= (w_next == S_WRITE) && (r_state != S_WRITE);
            if (w_latch) begin
                r_addr <= i_addr;
                r_hit  <= w_dec;
            end else if (w_next == S_IDLE) begin
                r_hit  <= 1'b0;
            end
            if (w_start) begin
                r_dir <= !i_rd_n;
                r_cnt <= WS_M1;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_WRITE && r_wfirst) r_mem[w_off] <= io_data;
        if (w_next == S_READ && r_state != S_READ) r_rdata <= r_mem[w_off];
    end

    assign io_data = (r_state == S_READ) ? r_rdata : 'z;
    assign o_ready = (r_state != S_WAIT);
    assign o_hit   = r_hit;
endmodule

// File: tb/tb_bus_slave_region.sv
// tb_bus_slave_region: a zero-wait memory region and a 3-wait I/O region on one bus;
// pulled-up data nets make an undriven bus read back as all ones.
module tb_bus_slave_region;
    localparam logic [7:0] ZV = 8'hFF;

    typedef struct {
        logic [7:0] em;
        logic [7:0] ei;
        int         wi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ale, iom, rd_n, wr_n;
    logic [19:0] addr;
    logic        drv;
    logic [7:0]  dval;
    wire  [7:0]  d_mem, d_io;
    wire         rdy_mem, rdy_io, hit_mem, hit_io;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    logic [7:0]  m_mem [256];
    logic [7:0]  m_io  [16];

    pullup (d_mem);
    pullup (d_io);
    assign d_mem = drv ? dval : 'z;
    assign d_io  = drv ? dval : 'z;

    always #5 clk = ~clk;

    bus_slave_region #(.BASE('h00000), .DEPTH(256), .IS_IO(1'b0), .WAIT_STATES(0)) u_mem (
        .i_clk(clk), .i_reset_n(rst_n), .i_ale(ale), .i_iom(iom), .i_rd_n(rd_n),
        .i_wr_n(wr_n), .i_addr(addr), .io_data(d_mem), .o_ready(rdy_mem), .o_hit(hit_mem)
    );

    bus_slave_region #(.BASE('h0FF00), .DEPTH(16), .IS_IO(1'b1), .WAIT_STATES(3)) u_io (
        .i_clk(clk), .i_reset_n(rst_n), .i_ale(ale), .i_iom(iom), .i_rd_n(rd_n),
        .i_wr_n(wr_n), .i_addr(addr), .io_data(d_io), .o_ready(rdy_io), .o_hit(hit_io)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hits_mem(input logic [19:0] a, input logic io);
        return !io && a <= 20'h000FF;
    endfunction

    function automatic bit hits_io(input logic [19:0] a, input logic io);
        return io && a >= 20'h0FF00 && a <= 20'h0FF0F;
    endfunction

    task automatic idle_checks(input string tag);
        chk({tag, "_zm"}, d_mem, ZV);
        chk({tag, "_zi"}, d_io, ZV);
        chk({tag, "_rdy"}, {rdy_mem, rdy_io}, 2'b11);
    endtask

    task automatic bus_write(input logic [19:0] a, input logic io, input logic [7:0] v);
        bit hm, hi;
        int wi;
        hm = hits_mem(a, io);
        hi = hits_io(a, io);
        @(negedge clk); ale = 1'b1; addr = a; iom = io;
        @(negedge clk);
        chk("wr_hit", {hit_mem, hit_io}, {hm, hi});
        ale = 1'b0; wr_n = 1'b0; drv = 1'b1; dval = v;
        wi = 0;
        @(negedge clk);
        for (int n = 0; n < 20 && rdy_io !== 1'b1; n++) begin
            wi++;
            @(negedge clk);
        end
        chk("wr_wait", wi, hi ? 3 : 0);
        @(negedge clk); dval = ~v;
        @(negedge clk); wr_n = 1'b1; drv = 1'b0;
        @(negedge clk);
        idle_checks("wr_tri");
        if (hm) m_mem[a[7:0]] = v;
        if (hi) m_io[a[3:0]] = v;
    endtask

    task automatic bus_read(input logic [19:0] a, input logic io, input bit both,
                            input bit dbl, input logic [19:0] pa);
        exp_t e;
        bit hm, hi;
        int wm, wi;
        hm = hits_mem(a, io);
        hi = hits_io(a, io);
        if (dbl) begin
            @(negedge clk); ale = 1'b1; addr = pa; iom = io;
        end
        @(negedge clk); ale = 1'b1; addr = a; iom = io;
        @(negedge clk);
        chk("rd_hit", {hit_mem, hit_io}, {hm, hi});
        ale = 1'b0; rd_n = 1'b0;
        if (both) wr_n = 1'b0;
        e.em = hm ? m_mem[a[7:0]] : ZV;
        e.ei = hi ? m_io[a[3:0]] : ZV;
        e.wi = hi ? 3 : 0;
        sb.push_back(e);
        wm = 0;
        wi = 0;
        @(negedge clk);
        for (int n = 0; n < 20 && (rdy_mem !== 1'b1 || rdy_io !== 1'b1); n++) begin
            if (rdy_mem !== 1'b1) wm++;
            if (rdy_io !== 1'b1) wi++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk("rd_wait_m", wm, 0);
        chk("rd_wait_i", wi, e.wi);
        chk("rd_data_m", d_mem, e.em);
        chk("rd_data_i", d_io, e.ei);
        @(negedge clk);
        chk("rd_hold", {d_mem, d_io}, {e.em, e.ei});
        rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        idle_checks("rd_tri");
    endtask

    initial begin
        rst_n = 1'b0; ale = 1'b0; iom = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; drv = 1'b0; dval = '0;
        repeat (2) @(negedge clk);
        idle_checks("rst");
        chk("rst_hit", {hit_mem, hit_io}, 2'b00);
        rst_n = 1'b1;

        bus_write(20'h00010, 1'b0, 8'hA5);
        bus_read (20'h00010, 1'b0, 1'b0, 1'b0, '0);
        bus_write(20'h0FF05, 1'b1, 8'h5A);
        bus_read (20'h0FF05, 1'b1, 1'b0, 1'b0, '0);
        bus_write(20'h0FF05, 1'b0, 8'h66);
        bus_read (20'h0FF05, 1'b0, 1'b0, 1'b0, '0);
        bus_read (20'h0FF05, 1'b1, 1'b0, 1'b0, '0);
        bus_read (20'h00010, 1'b1, 1'b0, 1'b0, '0);

        bus_write(20'h0FF0F, 1'b1, 8'h0F);
        bus_write(20'h0FF00, 1'b1, 8'h11);
        bus_write(20'h0FF10, 1'b1, 8'h22);
        bus_write(20'h000FF, 1'b0, 8'h77);
        bus_read (20'h0FF0F, 1'b1, 1'b0, 1'b0, '0);
        bus_read (20'h0FF00, 1'b1, 1'b0, 1'b0, '0);
        bus_read (20'h0FF10, 1'b1, 1'b0, 1'b0, '0);
        bus_read (20'h0FEFF, 1'b1, 1'b0, 1'b0, '0);
        bus_read (20'h00100, 1'b0, 1'b0, 1'b0, '0);
        bus_read (20'h000FF, 1'b0, 1'b0, 1'b0, '0);

        bus_read (20'h00010, 1'b0, 1'b1, 1'b0, '0);
        bus_read (20'h00010, 1'b0, 1'b0, 1'b0, '0);
        bus_read (20'h0FF05, 1'b1, 1'b1, 1'b0, '0);
        bus_read (20'h0FF05, 1'b1, 1'b0, 1'b0, '0);
        bus_read (20'h000FF, 1'b0, 1'b0, 1'b1, 20'h00010);

        @(negedge clk); ale = 1'b1; addr = 20'h00010; iom = 1'b0;
        @(negedge clk); ale = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        chk("pre_rst_data", d_mem, 8'hA5);
        #2 rst_n = 1'b0;
        #1;
        idle_checks("rst_rd");
        chk("rst_rd_hit", hit_mem, 1'b0);
        @(negedge clk); rd_n = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        idle_checks("post_rst");

        @(negedge clk); ale = 1'b1; addr = 20'h0FF05; iom = 1'b1;
        @(negedge clk); ale = 1'b0; wr_n = 1'b0; drv = 1'b1; dval = 8'hC3;
        @(negedge clk);
        chk("pre_rst_wait", rdy_io, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wait_rdy", rdy_io, 1'b1);
        @(negedge clk); wr_n = 1'b1; drv = 1'b0; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_wait_rdy", rdy_io, 1'b1);

        bus_read (20'h00010, 1'b0, 1'b0, 1'b0, '0);
        bus_read (20'h0FF05, 1'b1, 1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
